// File: rtl/regfile_dbg_port.sv
// Debug initiator for the CPU register file: dumps a register range onto an
// output stream or loads an input stream into a range, after stalling the core.
module regfile_dbg_port #(
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_first,
    input  logic [ADDR_W-1:0] cmd_last,
    output logic              hold_req,
    input  logic              hold_ack,
    output logic              rf_re,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    // Handshakes on cmd/out/in: a word moves on a rising edge where valid and
    // ready are both high; a source holds valid and its payload until then.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HOLD = 3'd1,
        S_RD   = 3'd2,
        S_OUT  = 3'd3,
        S_LOAD = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    // Highest implemented register; ranges reaching past it are rejected.
    localparam logic [ADDR_W:0] LAST_REG = (ADDR_W + 1)'(REG_NUM - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic                op_q, op_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic                out_last_q, out_last_d;
    logic                err_q, err_d;
    logic                at_last;
    logic                cmd_bad;

    assign at_last   = (addr_q == last_q);
    assign cmd_bad   = (cmd_first > cmd_last) || ({1'b0, cmd_last} > LAST_REG);
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        last_d     = last_q;
        op_d       = op_q;
        out_data_d = out_data_q;
        out_addr_d = out_addr_q;
        out_last_d = out_last_q;
        err_d      = 1'b0;
        cmd_ready  = 1'b0;
        hold_req   = 1'b0;
        rf_re      = 1'b0;
        rf_raddr   = '0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        in_ready   = 1'b0;
        done       = err_q;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = cmd_first;
                        last_d  = cmd_last;
                        op_d    = cmd_op;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                hold_req = 1'b1;
                if (hold_ack) begin
                    state_d = op_q ? S_LOAD : S_RD;
                end
            end
            S_RD: begin
                hold_req   = 1'b1;
                rf_re      = 1'b1;
                rf_raddr   = addr_q;
                out_data_d = rf_rdata;
                out_addr_d = addr_q;
                out_last_d = at_last;
                state_d    = S_OUT;
            end
            S_OUT: begin
                hold_req  = 1'b1;
                out_valid = 1'b1;
                out_last  = out_last_q;
                if (out_ready) begin
                    if (at_last) begin
                        state_d = S_FIN;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_RD;
                    end
                end
            end
            S_LOAD: begin
                hold_req = 1'b1;
                in_ready = 1'b1;
                rf_waddr = addr_q;
                rf_wdata = in_data;
                // Register 0 is hardwired: its word is consumed but dropped.
                rf_we    = in_valid && (addr_q != '0);
                if (in_valid) begin
                    if (at_last) begin
                        state_d = S_FIN;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            last_q     <= '0;
            op_q       <= 1'b0;
            out_data_q <= '0;
            out_addr_q <= '0;
            out_last_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            last_q     <= last_d;
            op_q       <= op_d;
            out_data_q <= out_data_d;
            out_addr_q <= out_addr_d;
            out_last_q <= out_last_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_regfile_dbg_port.sv
// Bench for regfile_dbg_port: register file and hold/ack models, directed
// commands, and scoreboard monitors for dump words, load writes and completions.
module tb_regfile_dbg_port;

    localparam int RN = 32;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_op = 1'b0;
    logic [AW-1:0] cmd_first = '0;
    logic [AW-1:0] cmd_last = '0;
    logic          hold_req;
    logic          hold_ack = 1'b0;
    logic          rf_re;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_last;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          busy;
    logic          done;
    logic          err;
    logic [2:0]    dbg_state;

    regfile_dbg_port #(.REG_NUM(RN), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_first(cmd_first), .cmd_last(cmd_last),
        .hold_req(hold_req), .hold_ack(hold_ack),
        .rf_re(rf_re), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- environment models ----------------
    logic [DW-1:0] rf_mem [RN] = '{1: 32'h11, 2: 32'h22, 3: 32'h33,
                                   6: 32'h66, 7: 32'h77, 31: 32'hDEAD_BEEF,
                                   default: 32'h0};
    assign rf_rdata = (rf_raddr == '0) ? '0 : rf_mem[rf_raddr];

    always @(posedge clk) begin
        if (rf_we && rf_waddr != '0) rf_mem[rf_waddr] <= rf_wdata;
    end

    int ack_dly = 2;
    int ack_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (hold_req) begin
            if (ack_cnt >= ack_dly) hold_ack = 1'b1;
            else ack_cnt++;
        end else begin
            hold_ack = 1'b0;
            ack_cnt  = 0;
        end
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_fail = 0;

    logic [AW+DW:0]   exp_out_q[$];  // {addr, data, last}
    logic [AW+DW:0]   exp_wr_q[$];   // {we, addr, data}
    logic             exp_done_q[$]; // err flag expected with the done pulse

    int done_cnt = 0;
    int in_hs_cnt = 0;
    int last_hs_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic          prev_stall = 1'b0;
    logic [AW+DW:0] prev_word = '0;

    always @(negedge clk) begin
        if (rst) begin
            if (prev_stall)
                check("out_stable", {out_valid, out_addr, out_data, out_last},
                      {1'b1, prev_word});
            if (out_valid && out_ready) begin
                if (exp_out_q.size() == 0) check("out_unexpected", 1, 0);
                else check("out_word", {out_addr, out_data, out_last}, exp_out_q.pop_front());
                last_hs_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_addr, out_data, out_last};

            if (in_valid && in_ready) begin
                in_hs_cnt++;
                if (exp_wr_q.size() == 0) check("wr_unexpected", 1, 0);
                else check("rf_write", {rf_we, rf_waddr, rf_wdata}, exp_wr_q.pop_front());
                last_hs_cyc = cyc;
            end

            if (done || err) begin
                done_cnt++;
                if (exp_done_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    logic e;
                    e = exp_done_q.pop_front();
                    check("done_err", {done, err}, {1'b1, e});
                    check("done_hold_low", hold_req, 0);
                    if (!e) check("done_latency", cyc - last_hs_cyc, 1);
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    logic [DW-1:0] ld_buf [4];

    task automatic do_cmd(input logic op, input logic [AW-1:0] first, input logic [AW-1:0] last);
        int guard = 0;
        @(negedge clk);
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_first = first; cmd_last = last;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int start = done_cnt;
        int guard = 0;
        while (done_cnt == start && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (done_cnt == start) check("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic load_words(input int n);
        int i = 0;
        int guard = 0;
        logic hs;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = ld_buf[0];
        while (i < n && guard < 300) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk); #1;
            if (hs) begin
                i++;
                if (i < n) in_data = ld_buf[i];
            end
            guard++;
        end
        in_valid = 1'b0;
        if (i < n) check("load_timeout", i, n);
    endtask

    task automatic wait_out_valid();
        int guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!out_valid) check("out_valid_timeout", 0, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int hs0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ctrl", {hold_req, out_valid, out_last, in_ready, done, err, busy}, 7'b0);
        check("rst_rf", {rf_re, rf_we, rf_raddr, rf_waddr, rf_wdata}, 0);
        check("rst_out", {out_data, out_addr}, 0);
        check("rst_state", dbg_state, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        rst = 1'b1;

        // Dump r1..r3 with a 2-cycle hold acknowledge
        ack_dly = 2;
        out_ready = 1'b1;
        exp_out_q.push_back({5'd1, 32'h11, 1'b0});
        exp_out_q.push_back({5'd2, 32'h22, 1'b0});
        exp_out_q.push_back({5'd3, 32'h33, 1'b1});
        exp_done_q.push_back(1'b0);
        do_cmd(1'b0, 5'd1, 5'd3);
        wait_done();

        // Load 0..2 back-to-back; the register-0 word is dropped
        ack_dly = $urandom_range(0, 3);
        ld_buf[0] = 32'hAA; ld_buf[1] = 32'hBB; ld_buf[2] = 32'hCC;
        exp_wr_q.push_back({1'b0, 5'd0, 32'hAA});
        exp_wr_q.push_back({1'b1, 5'd1, 32'hBB});
        exp_wr_q.push_back({1'b1, 5'd2, 32'hCC});
        exp_done_q.push_back(1'b0);
        hs0 = in_hs_cnt;
        do_cmd(1'b1, 5'd0, 5'd2);
        load_words(3);
        wait_done();
        check("load_hs_count", in_hs_cnt - hs0, 3);
        check("mem_r0", rf_mem[0], 32'h0);
        check("mem_r1", rf_mem[1], 32'hBB);
        check("mem_r2", rf_mem[2], 32'hCC);

        exp_out_q.push_back({5'd0, 32'h0, 1'b0});
        exp_out_q.push_back({5'd1, 32'hBB, 1'b0});
        exp_out_q.push_back({5'd2, 32'hCC, 1'b1});
        exp_done_q.push_back(1'b0);
        do_cmd(1'b0, 5'd0, 5'd2);
        wait_done();

        // Single-word dump of r31 with the sink stalled for 5 cycles
        out_ready = 1'b0;
        exp_out_q.push_back({5'd31, 32'hDEAD_BEEF, 1'b1});
        exp_done_q.push_back(1'b0);
        do_cmd(1'b0, 5'd31, 5'd31);
        wait_out_valid();
        check("stall_word", {out_valid, out_addr, out_data, out_last}, {1'b1, 5'd31, 32'hDEAD_BEEF, 1'b1});
        repeat (5) @(negedge clk);
        check("stall_valid", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done();

        // Inverted range is rejected without stalling the core
        exp_done_q.push_back(1'b1);
        do_cmd(1'b0, 5'd5, 5'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("err_no_hold", hold_req, 0);
            check("err_cmd_ready", cmd_ready, 1);
        end

        // Load 4..7 aborted by reset after two words
        ld_buf[0] = 32'h44; ld_buf[1] = 32'h55; ld_buf[2] = 32'hBAD6; ld_buf[3] = 32'hBAD7;
        exp_wr_q.push_back({1'b1, 5'd4, 32'h44});
        exp_wr_q.push_back({1'b1, 5'd5, 32'h55});
        do_cmd(1'b1, 5'd4, 5'd7);
        load_words(2);
        in_valid = 1'b1;
        in_data  = 32'hBAD6;
        #1;
        rst = 1'b0;
        #1;
        check("abort_ctrl", {hold_req, out_valid, out_last, in_ready, done, err, busy}, 7'b0);
        check("abort_rf", {rf_re, rf_we, rf_raddr, rf_waddr, rf_wdata}, 0);
        check("abort_out", {out_data, out_addr}, 0);
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_state", dbg_state, 0);
        check("abort_r4", rf_mem[4], 32'h44);
        check("abort_r5", rf_mem[5], 32'h55);
        check("abort_r6", rf_mem[6], 32'h66);
        check("abort_r7", rf_mem[7], 32'h77);

        // Command presented while busy in OUT is ignored
        ack_dly = $urandom_range(0, 3);
        out_ready = 1'b0;
        exp_out_q.push_back({5'd1, 32'hBB, 1'b0});
        exp_out_q.push_back({5'd2, 32'hCC, 1'b1});
        exp_done_q.push_back(1'b0);
        do_cmd(1'b0, 5'd1, 5'd2);
        wait_out_valid();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_first = 5'd0; cmd_last = 5'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("busy_cmd_ready", cmd_ready, 0);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        out_ready = 1'b1;
        wait_done();
        repeat (3) @(negedge clk);
        check("final_state", dbg_state, 0);

        check("left_out", exp_out_q.size(), 0);
        check("left_wr", exp_wr_q.size(), 0);
        check("left_done", exp_done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
